// File: rtl/solicitante_pkg.sv
// Shared definitions for the polynomial requester.
// This file holds the controller states, the operand bundle and the data/FIFO/timeout sizing.
package solicitante_pkg;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 255;

    // The operand table has as many entries as one batch can request.
    localparam int TBL_DEPTH  = 4;
    localparam int IDX_W      = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int TMO_W      = 8;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        EMITE   = 3'd1,
        ESPERA  = 3'd2,
        CAPTURA = 3'd3,
        LIBERA  = 3'd4,
        ERRO    = 3'd5
    } estado_t;

    // One operand set as presented to the evaluator.
    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
    } operandos_t;

    // A batch is in flight in every state between the request and its release.
    function automatic logic estado_busy(input estado_t s);
        return (s == EMITE) || (s == ESPERA) || (s == CAPTURA) || (s == LIBERA);
    endfunction

    // The operand table may only change while no batch is using it.
    function automatic logic estado_parado(input estado_t s);
        return (s == OCIOSO) || (s == ERRO);
    endfunction

endpackage

// File: rtl/solicitante_polinomio_fifo.sv
// Result FIFO: four entries with a show-ahead head.
// The output reads zero when the FIFO is empty. A pop on an empty FIFO is ignored.
// A push on a full FIFO is dropped. The controller never attempts that push.
module fifo_resultado
    import solicitante_pkg::*;
(
    input  logic              ck,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              vazio,
    output logic              cheio
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign vazio   = (cnt_q == '0);
    assign cheio   = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !cheio;
    assign do_pop  = pop && !vazio;
    assign dout    = vazio ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally at the depth. The count only changes when exactly one side moves.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers. Reset empties the FIFO.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array with no reset. The empty flag masks any stale data on the head.
    always_ff @(posedge ck) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/solicitante_polinomio.sv
// Polynomial requester: replays a batch of operand sets to an external evaluator.
// It handles the request strobe, waits for the result and acknowledges it.
// It then queues the result in a small FIFO.
// A stuck evaluator is caught by an 8-bit timeout.
module solicitante_polinomio
    import solicitante_pkg::*;
(
    input  logic              ck,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_X,
    input  logic [DATA_W-1:0] wr_A,
    input  logic [DATA_W-1:0] wr_B,
    input  logic [DATA_W-1:0] wr_C,
    input  logic [1:0]        n_ops,
    input  logic              go,
    output logic [DATA_W-1:0] X,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic              inicio,
    output logic              pronto,
    input  logic              done,
    input  logic [DATA_W-1:0] Resultado,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_dado,
    output logic              vazio,
    output logic              cheio,
    output logic              busy,
    output logic              erro
);

    estado_t          estado_q, estado_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] nops_q, nops_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             erro_q, erro_d;
    logic             fifo_push;
    logic             tmo_fim;
    logic             tbl_we;
    operandos_t       tbl_q [TBL_DEPTH];
    operandos_t       op_sel;

    // The next count reaching the limit is the last cycle the evaluator is allowed.
    assign tmo_fim = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign tbl_we  = wr_en && estado_parado(estado_q);

    // Operand table with no reset. It is writable only while no batch depends on it.
    always_ff @(posedge ck) begin
        if (tbl_we) begin
            tbl_q[wr_addr] <= '{x: wr_X, a: wr_A, b: wr_B, c: wr_C};
        end
    end

    // Controller register stage. Reset abandons any batch immediately.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            estado_q <= OCIOSO;
            idx_q    <= '0;
            nops_q   <= '0;
            tmo_q    <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            nops_q   <= nops_d;
            tmo_q    <= tmo_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state and strobe decode for the request/capture/release handshake.
    always_comb begin
        estado_d  = estado_q;
        idx_d     = idx_q;
        nops_d    = nops_q;
        tmo_d     = tmo_q;
        erro_d    = erro_q;
        fifo_push = 1'b0;
        inicio    = 1'b0;
        pronto    = 1'b0;
        case (estado_q)
            OCIOSO, ERRO: begin
                if (go) begin
                    erro_d   = 1'b0;
                    idx_d    = '0;
                    nops_d   = n_ops;
                    estado_d = EMITE;
                end
            end
            EMITE: begin
                inicio   = 1'b1;
                tmo_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (done) begin
                    // A full FIFO stalls the capture. This is backpressure, not a stuck
                    // evaluator, so the timeout does not advance.
                    if (!cheio) begin
                        fifo_push = 1'b1;
                        estado_d  = CAPTURA;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_fim) begin
                        erro_d   = 1'b1;
                        estado_d = ERRO;
                    end
                end
            end
            CAPTURA: begin
                pronto   = 1'b1;
                estado_d = LIBERA;
            end
            LIBERA: begin
                if (!done) begin
                    if (idx_q < nops_q) begin
                        idx_d    = idx_q + 1'b1;
                        estado_d = EMITE;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end else begin
                    // The evaluator must drop done after the acknowledge.
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_fim) begin
                        erro_d   = 1'b1;
                        estado_d = ERRO;
                    end
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Operands are held for the whole request and read as zero when no batch is active.
    always_comb begin
        op_sel = '0;
        if (estado_busy(estado_q)) begin
            op_sel = tbl_q[idx_q];
        end
    end

    assign X    = op_sel.x;
    assign A    = op_sel.a;
    assign B    = op_sel.b;
    assign C    = op_sel.c;
    assign busy = estado_busy(estado_q);
    assign erro = erro_q;

    fifo_resultado u_fifo (
        .ck    (ck),
        .rst   (rst),
        .push  (fifo_push),
        .din   (Resultado),
        .pop   (rd_en),
        .dout  (rd_dado),
        .vazio (vazio),
        .cheio (cheio)
    );

endmodule
